// File: rtl/layer_pkg.sv
// Shared types and helpers for the fully-connected layer block (layer_tm).
package layer_pkg;

   // Layer sequencing states.
   typedef enum logic [1:0] {StIdle, StCompute, StAct, StDone} state_e;

   // Working width for the bias-add / shift / saturate stage; wide enough for any sane accumulator.
   localparam int unsigned CALC_W = 64;

   // Accumulator width: full product plus growth for num_weight terms plus one guard bit.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned num_weight);
      return 2 * data_width + $clog2(num_weight) + 1;
   endfunction

   // Arithmetic right shift by frac_bits, then clamp into a signed data_width range.
   function automatic logic signed [CALC_W-1:0] sat_shift(input logic signed [CALC_W-1:0] val,
                                                          input int unsigned frac_bits,
                                                          input int unsigned data_width);
      logic signed [CALC_W-1:0] shifted;
      logic signed [CALC_W-1:0] max_v;
      logic signed [CALC_W-1:0] min_v;
      shifted = val >>> frac_bits;
      max_v   = (64'sd1 <<< (data_width - 1)) - 64'sd1;
      min_v   = -max_v - 64'sd1;
      if (shifted > max_v) begin
         return max_v;
      end else if (shifted < min_v) begin
         return min_v;
      end
      return shifted;
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: accumulates data*weight products, then adds the bias, rescales, saturates
// and applies the optional activation. Define LAYER_TM_RELU_EN to clamp negative results to 0.
module mac_lane
   import layer_pkg::*;
#(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned FracBits  = 8,
   parameter int unsigned AccWidth  = 35
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        acc_en_i,
   input  logic                        clear_i,
   input  logic signed [DataWidth-1:0] data_i,
   input  logic signed [DataWidth-1:0] weight_i,
   input  logic signed [DataWidth-1:0] bias_i,
   output logic signed [DataWidth-1:0] result_o
);

   logic signed [2*DataWidth-1:0] prod;
   logic signed [AccWidth-1:0]    acc_q, acc_d;
   logic signed [CALC_W-1:0]      sum;
   logic signed [CALC_W-1:0]      sat;
   logic                          unused_sat;

   assign prod = (2 * DataWidth)'(data_i) * (2 * DataWidth)'(weight_i);

   // Accumulator next state: clear after the result has been taken, otherwise accumulate.
   always_comb begin
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (acc_en_i) begin
         acc_d = acc_q + AccWidth'(prod);
      end
   end

   // Accumulator register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Bias is aligned to the product's binary point before the final rescale.
   always_comb begin
      sum = CALC_W'(acc_q) + (CALC_W'(bias_i) <<< FracBits);
      sat = sat_shift(sum, FracBits, DataWidth);
`ifdef LAYER_TM_RELU_EN
      result_o = sat[CALC_W-1] ? '0 : sat[DataWidth-1:0];
`else
      result_o = sat[DataWidth-1:0];
`endif
   end

   // Upper bits only carry the sign after saturation.
   assign unused_sat = ^sat[CALC_W-1:DataWidth];

endmodule

// File: rtl/layer_tm.sv
// Time-multiplexed fully-connected layer: buffers one input vector, runs NUM_PE MAC lanes over
// ceil(NUM_NEURON/NUM_PE) passes and presents the whole output vector with valid/ready.
// Optional ReLU activation is enabled by defining LAYER_TM_RELU_EN.
module layer_tm
   import layer_pkg::*;
#(
   parameter int unsigned NUM_NEURON = 10,
   parameter int unsigned NUM_WEIGHT = 30,
   parameter int unsigned NUM_PE     = 2,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 8,
   parameter int unsigned LAYER_ID   = 1
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [DATA_WIDTH-1:0]            i_input,
   input  logic                             i_input_valid,
   output logic                             o_input_ready,
   input  logic [31:0]                      i_weight,
   input  logic                             i_weight_valid,
   input  logic [31:0]                      i_bias,
   input  logic                             i_bias_valid,
   input  logic [31:0]                      i_layer_id,
   input  logic [31:0]                      i_neuron_id,
   output logic [NUM_NEURON*DATA_WIDTH-1:0] o_output,
   output logic                             o_output_valid,
   input  logic                             i_output_ready
);

   localparam int unsigned NumPass = (NUM_NEURON + NUM_PE - 1) / NUM_PE;
   localparam int unsigned CntW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
   localparam int unsigned PassW   = (NumPass > 1) ? $clog2(NumPass) : 1;
   localparam int unsigned NidW    = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
   localparam int unsigned AccW    = acc_width(DATA_WIDTH, NUM_WEIGHT);

   state_e                                   state_q, state_d;
   logic [CntW-1:0]                          cnt_q, cnt_d;
   logic [PassW-1:0]                         pass_q, pass_d;
   logic [CntW-1:0]                          widx_q, widx_d;
   logic [31:0]                              prev_nid_q, prev_nid_d;
   logic [NUM_NEURON-1:0][DATA_WIDTH-1:0]    out_q, out_d;

   // Storage that deliberately survives reset.
   logic [DATA_WIDTH-1:0] in_buf [NUM_WEIGHT];
   logic [DATA_WIDTH-1:0] w_mem  [NUM_NEURON][NUM_WEIGHT];
   logic [DATA_WIDTH-1:0] b_mem  [NUM_NEURON];

   logic                  in_acc;
   logic                  wr_ok;
   logic                  w_wr;
   logic                  b_wr;
   logic [NidW-1:0]       nid;
   logic [CntW-1:0]       widx_eff;
   logic                  acc_en;
   logic                  act;
   logic [DATA_WIDTH-1:0] lane_x;
   logic [DATA_WIDTH-1:0] lane_w   [NUM_PE];
   logic [DATA_WIDTH-1:0] lane_b   [NUM_PE];
   logic [DATA_WIDTH-1:0] lane_res [NUM_PE];
   logic                  unused_hi;

   assign in_acc   = (state_q == StIdle) && i_input_valid;
   assign wr_ok    = (state_q == StIdle) && (i_layer_id == LAYER_ID) && (i_neuron_id < NUM_NEURON);
   assign w_wr     = i_weight_valid && wr_ok;
   assign b_wr     = i_bias_valid && wr_ok;
   assign nid      = i_neuron_id[NidW-1:0];
   // A write to a different neuron restarts its weight index.
   assign widx_eff = (i_neuron_id != prev_nid_q) ? '0 : widx_q;
   assign acc_en   = (state_q == StCompute);
   assign act      = (state_q == StAct);
   assign lane_x   = in_buf[cnt_q];

   assign unused_hi = ^{i_weight[31:DATA_WIDTH], i_bias[31:DATA_WIDTH]};

   // Sequencer next state: collect inputs, NUM_WEIGHT MAC cycles per pass, one ACT cycle per pass.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      unique case (state_q)
         StIdle: begin
            if (in_acc) begin
               if (cnt_q == CntW'(NUM_WEIGHT - 1)) begin
                  state_d = StCompute;
                  cnt_d   = '0;
                  pass_d  = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StCompute: begin
            if (cnt_q == CntW'(NUM_WEIGHT - 1)) begin
               state_d = StAct;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StAct: begin
            if (pass_q == PassW'(NumPass - 1)) begin
               state_d = StDone;
               pass_d  = '0;
            end else begin
               state_d = StCompute;
               pass_d  = pass_q + PassW'(1);
            end
         end
         StDone: begin
            if (i_output_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Weight write index advances per accepted weight write and wraps at the row end.
   always_comb begin
      widx_d     = widx_q;
      prev_nid_d = prev_nid_q;
      if (w_wr) begin
         widx_d     = (widx_eff == CntW'(NUM_WEIGHT - 1)) ? '0 : widx_eff + CntW'(1);
         prev_nid_d = i_neuron_id;
      end
   end

   // Route the current pass's neurons onto the lanes; lanes past the last neuron see zeros.
   always_comb begin
      for (int unsigned l = 0; l < NUM_PE; l++) begin
         lane_w[l] = '0;
         lane_b[l] = '0;
      end
      for (int unsigned n = 0; n < NUM_NEURON; n++) begin
         if (PassW'(n / NUM_PE) == pass_q) begin
            lane_w[n % NUM_PE] = w_mem[n][cnt_q];
            lane_b[n % NUM_PE] = b_mem[n];
         end
      end
   end

   // Capture lane results into the output slots of the pass just finished.
   always_comb begin
      out_d = out_q;
      if (act) begin
         for (int unsigned n = 0; n < NUM_NEURON; n++) begin
            if (PassW'(n / NUM_PE) == pass_q) begin
               out_d[n] = lane_res[n % NUM_PE];
            end
         end
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         pass_q     <= '0;
         widx_q     <= '0;
         prev_nid_q <= '0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pass_q     <= pass_d;
         widx_q     <= widx_d;
         prev_nid_q <= prev_nid_d;
         out_q      <= out_d;
      end
   end

   // Input, weight and bias storage; qualification already folds in the IDLE-only rule.
   always_ff @(posedge i_clk) begin
      if (in_acc) begin
         in_buf[cnt_q] <= i_input;
      end
      if (w_wr) begin
         w_mem[nid][widx_eff] <= i_weight[DATA_WIDTH-1:0];
      end
      if (b_wr) begin
         b_mem[nid] <= i_bias[DATA_WIDTH-1:0];
      end
   end

   for (genvar l = 0; l < NUM_PE; l++) begin : g_lane
      mac_lane #(
         .DataWidth (DATA_WIDTH),
         .FracBits  (FRAC_BITS),
         .AccWidth  (AccW)
      ) u_lane (
         .clk_i    (i_clk),
         .rst_ni   (i_reset),
         .acc_en_i (acc_en),
         .clear_i  (act),
         .data_i   (lane_x),
         .weight_i (lane_w[l]),
         .bias_i   (lane_b[l]),
         .result_o (lane_res[l])
      );
   end

   assign o_output       = out_q;
   assign o_input_ready  = (state_q == StIdle);
   assign o_output_valid = (state_q == StDone);

endmodule

// File: tb/tb_layer_tm.sv
// Self-checking bench for layer_tm (3 neurons, 4 weights, 2 lanes, Q8.8).
module tb_layer_tm;

   localparam int NN    = 3;
   localparam int NW    = 4;
   localparam int NPE   = 2;
   localparam int DW    = 16;
   localparam int FB    = 8;
   localparam int NPASS = (NN + NPE - 1) / NPE;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     i_input;
   logic              i_input_valid;
   logic              o_input_ready;
   logic [31:0]       i_weight;
   logic              i_weight_valid;
   logic [31:0]       i_bias;
   logic              i_bias_valid;
   logic [31:0]       i_layer_id;
   logic [31:0]       i_neuron_id;
   logic [NN*DW-1:0]  o_output;
   logic              o_output_valid;
   logic              i_output_ready;

   always #5 clk = ~clk;

   layer_tm #(
      .NUM_NEURON (NN),
      .NUM_WEIGHT (NW),
      .NUM_PE     (NPE),
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FB),
      .LAYER_ID   (1)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst_n),
      .i_input        (i_input),
      .i_input_valid  (i_input_valid),
      .o_input_ready  (o_input_ready),
      .i_weight       (i_weight),
      .i_weight_valid (i_weight_valid),
      .i_bias         (i_bias),
      .i_bias_valid   (i_bias_valid),
      .i_layer_id     (i_layer_id),
      .i_neuron_id    (i_neuron_id),
      .o_output       (o_output),
      .o_output_valid (o_output_valid),
      .i_output_ready (i_output_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_w   [NN][NW];
   logic [DW-1:0] m_b   [NN];
   logic [DW-1:0] m_in  [NW];
   logic [DW-1:0] m_out [NN];
   int            m_phase;  // 0 accepting, 1 busy, 2 presenting
   int            m_cnt;
   int            m_left;
   int            m_widx;
   int            m_idx;
   logic [31:0]   m_prev;
   logic          chk_en = 1'b0;

   function automatic logic [DW-1:0] neuron_value(input int n);
      longint s;
      s = 0;
      for (int k = 0; k < NW; k++) begin
         s += longint'($signed(m_in[k])) * longint'($signed(m_w[n][k]));
      end
      s += longint'($signed(m_b[n])) * (64'sd1 <<< FB);
      s = s >>> FB;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`ifdef LAYER_TM_RELU_EN
      if (s < 0) s = 0;
`endif
      return DW'(s);
   endfunction

   function automatic logic [63:0] model_vec();
      logic [NN*DW-1:0] v;
      for (int n = 0; n < NN; n++) v[n*DW +: DW] = m_out[n];
      return 64'(v);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = 0;
         m_cnt   = 0;
         m_widx  = 0;
         m_prev  = 0;
         for (int n = 0; n < NN; n++) m_out[n] = '0;
      end else begin
         case (m_phase)
            0: begin
               if (i_layer_id == 32'd1 && i_neuron_id < NN) begin
                  if (i_weight_valid) begin
                     m_idx = (i_neuron_id == m_prev) ? m_widx : 0;
                     m_w[i_neuron_id][m_idx] = i_weight[DW-1:0];
                     m_widx = (m_idx + 1) % NW;
                     m_prev = i_neuron_id;
                  end
                  if (i_bias_valid) m_b[i_neuron_id] = i_bias[DW-1:0];
               end
               if (i_input_valid) begin
                  m_in[m_cnt] = i_input;
                  if (m_cnt == NW - 1) begin
                     m_cnt   = 0;
                     m_phase = 1;
                     m_left  = NPASS * (NW + 1);
                  end else begin
                     m_cnt++;
                  end
               end
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  for (int n = 0; n < NN; n++) m_out[n] = neuron_value(n);
                  m_phase = 2;
               end
            end
            default: begin
               if (i_output_ready) m_phase = 0;
            end
         endcase
      end
   end

   // Cycle-by-cycle comparison against the model; the vector is only settled outside busy.
   always @(negedge clk) begin
      if (chk_en) begin
         check("input_ready", 64'(o_input_ready), 64'(m_phase == 0));
         check("output_valid", 64'(o_output_valid), 64'(m_phase == 2));
         if (m_phase != 1) check("output_vec", 64'(o_output), model_vec());
      end
   end

   // ---------------- stimulus ----------------
   task automatic write_weight(input int layer, input int nid, input logic [DW-1:0] v);
      i_layer_id = 32'(layer); i_neuron_id = 32'(nid);
      i_weight = {16'hA5A5, v}; i_weight_valid = 1'b1;
      @(negedge clk);
      i_weight_valid = 1'b0;
   endtask

   task automatic write_bias(input int layer, input int nid, input logic [DW-1:0] v);
      i_layer_id = 32'(layer); i_neuron_id = 32'(nid);
      i_bias = {16'h5A5A, v}; i_bias_valid = 1'b1;
      @(negedge clk);
      i_bias_valid = 1'b0;
   endtask

   task automatic load_all(input logic [DW-1:0] wv, input logic [DW-1:0] bv);
      for (int n = 0; n < NN; n++) begin
         for (int k = 0; k < NW; k++) write_weight(1, n, wv);
         write_bias(1, n, bv);
      end
   endtask

   task automatic send_only(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                            input logic [DW-1:0] x2, input logic [DW-1:0] x3);
      logic [DW-1:0] xs [NW];
      xs = '{x0, x1, x2, x3};
      for (int k = 0; k < NW; k++) begin
         i_input = xs[k]; i_input_valid = 1'b1;
         @(negedge clk);
      end
      i_input_valid = 1'b0;
   endtask

   // Sends a vector and counts edges from the last accepting edge until valid is seen.
   task automatic run_inputs(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                             input logic [DW-1:0] x2, input logic [DW-1:0] x3,
                             input int bias_nid, input logic [DW-1:0] bias_v, output int lat);
      logic [DW-1:0] xs [NW];
      xs = '{x0, x1, x2, x3};
      for (int k = 0; k < NW - 1; k++) begin
         i_input = xs[k]; i_input_valid = 1'b1;
         if (k == 0 && bias_nid >= 0) begin
            i_layer_id = 32'd1; i_neuron_id = 32'(bias_nid);
            i_bias = 32'(bias_v); i_bias_valid = 1'b1;
         end
         @(negedge clk);
         i_bias_valid = 1'b0;
      end
      i_input = xs[NW-1]; i_input_valid = 1'b1;
      @(posedge clk);
      #1 i_input_valid = 1'b0;
      lat = 0;
      while (!o_output_valid && lat < 60) begin
         @(posedge clk);
         lat++;
         #1;
      end
      @(negedge clk);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!o_output_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("valid_within_bound", 64'(o_output_valid), 64'd1);
   endtask

   task automatic consume();
      i_output_ready = 1'b1;
      @(negedge clk);
      i_output_ready = 1'b0;
   endtask

   int            lat;
   logic [DW-1:0] neg_exp;

   initial begin
      rst_n = 1'b0;
      i_input = '0; i_input_valid = 1'b0;
      i_weight = '0; i_weight_valid = 1'b0;
      i_bias = '0; i_bias_valid = 1'b0;
      i_layer_id = 32'd1; i_neuron_id = '0;
      i_output_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_output", 64'(o_output), 64'd0);
      check("reset_valid", 64'(o_output_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", 64'(o_input_ready), 64'd1);

      // Unit weights, zero bias: 1.0 + 2.0 + 0.5 + 0.25 = 3.75.
      load_all(16'h0100, 16'h0000);
      run_inputs(16'h0100, 16'h0200, 16'h0080, 16'h0040, -1, '0, lat);
      check("basic_latency", 64'(lat), 64'd10);
      check("basic_result", 64'(o_output), 64'h03C0_03C0_03C0);
      consume();

      // Unqualified writes in IDLE, then qualified-looking writes while computing.
      for (int k = 0; k < NW; k++) write_weight(2, 0, 16'h7FFF);
      for (int k = 0; k < NW; k++) write_weight(1, 3, 16'h7FFF);
      write_bias(2, 1, 16'h7FFF);
      write_bias(1, 3, 16'h7FFF);
      send_only(16'h0100, 16'h0200, 16'h0080, 16'h0040);
      i_layer_id = 32'd1; i_neuron_id = 32'd0;
      i_weight = 32'h7FFF; i_bias = 32'h7FFF;
      i_weight_valid = 1'b1; i_bias_valid = 1'b1;
      repeat (6) @(negedge clk);
      i_weight_valid = 1'b0; i_bias_valid = 1'b0;
      wait_valid();
      check("ignored_writes_result", 64'(o_output), 64'h03C0_03C0_03C0);
      consume();

      // Reset a few cycles into the computation; stored weights must survive.
      send_only(16'h0100, 16'h0200, 16'h0080, 16'h0040);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_output", 64'(o_output), 64'd0);
      check("abort_valid", 64'(o_output_valid), 64'd0);
      check("abort_ready", 64'(o_input_ready), 64'd1);
      run_inputs(16'h0100, 16'h0200, 16'h0080, 16'h0040, -1, '0, lat);
      check("after_abort_result", 64'(o_output), 64'h03C0_03C0_03C0);
      consume();

      // Positive saturation.
      load_all(16'h7FFF, 16'h7FFF);
      run_inputs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, -1, '0, lat);
      check("sat_result", 64'(o_output), 64'h7FFF_7FFF_7FFF);
      consume();

      // Negative result: -4.0, clamped to zero when the activation is enabled.
      load_all(16'hFF00, 16'h0000);
      run_inputs(16'h0100, 16'h0100, 16'h0100, 16'h0100, -1, '0, lat);
`ifdef LAYER_TM_RELU_EN
      neg_exp = 16'h0000;
`else
      neg_exp = 16'hFC00;
`endif
      check("neg_result", 64'(o_output), 64'({neg_exp, neg_exp, neg_exp}));

      // Backpressure: hold in DONE while offering inputs that must be dropped.
      i_input = 16'h1234; i_input_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("hold_valid", 64'(o_output_valid), 64'd1);
         check("hold_ready", 64'(o_input_ready), 64'd0);
         check("hold_output", 64'(o_output), 64'({neg_exp, neg_exp, neg_exp}));
      end
      i_input_valid = 1'b0;
      consume();
      check("release_idle", 64'(o_input_ready), 64'd1);

      // Per-neuron weights exercise lane mapping, index restart on neuron change and wrap.
      write_weight(1, 0, 16'h0100); write_weight(1, 0, 16'h0000);
      write_weight(1, 0, 16'h0000); write_weight(1, 0, 16'h0000);
      write_weight(1, 1, 16'h0000); write_weight(1, 1, 16'h0100);
      write_weight(1, 1, 16'h0000); write_weight(1, 1, 16'h0000);
      write_weight(1, 2, 16'h0999); write_weight(1, 2, 16'h0777);
      write_weight(1, 2, 16'h0100); write_weight(1, 2, 16'h0000);
      write_weight(1, 2, 16'h0000); write_weight(1, 2, 16'h0000);
      write_bias(1, 1, 16'h0020);
      write_bias(1, 2, 16'hFFD0);
      run_inputs(16'h0100, 16'h0200, 16'h0080, 16'h0040, 0, 16'h0010, lat);
      check("map_latency", 64'(lat), 64'd10);
      check("map_result", 64'(o_output), 64'h0050_0220_0110);
      consume();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case any sequence stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
